treasure_classifier: RTL and testbench
======================================

Name: treasure_classifier

Overview:
Consumes the RGB332 pixel stream read from the frame M9K during the VGA scan on the 25 MHz VGA clock. Counts red and blue pixels in three horizontal bands of the 176x144 image. At each frame end it classifies the dominant colour and the shape, then publishes COLOR/SHAPE with a one-cycle valid strobe. The top level drives the Arduino GPIO pins from these outputs.

Parameters:
WIDTH, 176, active image width in pixels
HEIGHT, 144, active image height in rows; bands are rows [0,47], [48,95], [96,143]
RED_MIN, 3'd6, minimum R field for a red pixel
BLUE_MIN, 2'd2, minimum B field for a blue pixel
MIN_COUNT, 15'd400, minimum dominant-colour pixel total for a detection
PIXEL_LATENCY, 1, CLK cycles from VGA_PIXEL_X/Y to matching PIXEL_IN (M9K registered read)

Ports:
CLK  in  1  VGA pixel clock (25 MHz)
RESET_NEG  in  1  asynchronous active-low reset
PIXEL_IN  in  8  RGB332 pixel {R[7:5],G[4:2],B[1:0]} from memory read port
VGA_PIXEL_X  in  10  current scan column
VGA_PIXEL_Y  in  10  current scan row
VGA_VSYNC_NEG  in  1  VGA vertical sync, active low
COLOR  out  2  00 none, 01 red, 10 blue (11 unused)
SHAPE  out  2  00 none, 01 triangle, 10 square, 11 diamond
RESULT_VALID  out  1  one-cycle strobe when COLOR/SHAPE update

Behaviour:
- Reset (RESET_NEG low, async): COLOR=0, SHAPE=0, RESULT_VALID=0, all counters 0, state SYNC_WAIT, prev_vsync=1.
- X/Y are delayed PIXEL_LATENCY cycles through a register pipe so they align with PIXEL_IN. The pixel is in window when delayed X<WIDTH and Y<HEIGHT.
- Pixel class:
  - red: R>=RED_MIN, G<3, B<BLUE_MIN
  - blue: B>=BLUE_MIN, R<3, G<3
  - otherwise: ignored
  - E0 is red, 03 is blue, 1C is neither.
- Counters: six 15-bit counters, red_t/m/b and blue_t/m/b. A counter increments by 1 for an in-window pixel of its class in its band, only in state ACCUM. Counters saturate at 15'h7FFF and never wrap.
- Frame-end edge fe = prev_vsync & ~VGA_VSYNC_NEG, where prev_vsync is registered every cycle.
- States:
  - SYNC_WAIT: on fe, clear counters and go to ACCUM. Discards the partial frame after reset.
  - ACCUM: count pixels; on fe go to EVAL_A.
  - EVAL_A: register totals R=sum red bands and B=sum blue bands (17-bit sums). Dominant = red if R>=B, else blue. Latch the dominant band counts t,m,b.
  - EVAL_B: compute colour and shape.
    - Colour: if dominant total < MIN_COUNT, colour none and shape none.
    - Shape priority: triangle if (t<<1)<=b and t<m and m<b; else square if |t-b|<=(b>>2) and |m-b|<=(b>>2); else diamond if m>t and m>b; else none. Differences are unsigned magnitudes on 16 bits.
  - PUBLISH: register COLOR/SHAPE, RESULT_VALID=1 for this cycle only, clear counters, go to ACCUM.
- Latency: if fe is detected at cycle N (first sample of VSYNC low), outputs change and RESULT_VALID is high at cycle N+4.
- Pixels arriving during EVAL_A, EVAL_B or PUBLISH are dropped (vertical blanking). fe during these states is ignored.
- COLOR/SHAPE hold their value between publishes, including undetected frames, which publish 00/00.
- Reset mid-frame returns the block to SYNC_WAIT. No output is produced until the first complete frame.

Optional Feature:
FRAME_VOTE_EN
- Defined: PUBLISH updates COLOR/SHAPE only if the new {colour,shape} equals the candidate registered at the previous PUBLISH. The candidate is always updated. RESULT_VALID pulses only when the outputs actually change. The candidate resets to 0.
- Undefined: every PUBLISH updates the outputs and pulses RESULT_VALID.

Decomposition:
- Package treasure_pkg holds:
  - COLOR_NONE/RED/BLUE and SHAPE_NONE/TRI/SQUARE/DIAMOND encodings
  - state encoding
  - band boundaries, derived as HEIGHT/3 and 2*HEIGHT/3
- Sub-module band_counter: one saturating 15-bit counter with inc, clr and sat. It is instantiated six times.

Test Plan:
- Reset, then a full frame of E0 in rows 0..143: first frame end after reset gives no RESULT_VALID; second gives COLOR=01. Every row is filled, so t=m=b=8448 and SHAPE=10.
- Blue frame (03) with band fills t=1000, m=3000, b=6000 -> COLOR=10, SHAPE=01, RESULT_VALID high exactly at N+4.
- Red band fills t=500, m=4000, b=500 -> COLOR=01, SHAPE=11. Equal red/blue totals of 3000 each -> COLOR=01 (tie goes to red).
- Frame of all 1C, then a frame with only 300 red pixels -> COLOR=00, SHAPE=00 both frames, valid still pulsed each frame.
- Assert RESET_NEG low mid-ACCUM, release -> outputs 0 immediately; the next fe yields no valid; the following frame classifies correctly.
- With FRAME_VOTE_EN: red-square, blue-tri, blue-tri frames -> outputs update only after the third frame, single RESULT_VALID.

Source files
------------

// File: rtl/treasure_pkg.sv
// Shared geometry, thresholds, encodings and shape helper for the treasure classifier.
package treasure_pkg;

    localparam int WIDTH         = 176;
    localparam int HEIGHT        = 144;
    localparam int PIXEL_LATENCY = 1;

    localparam logic [9:0] WIDTH_PX   = 10'(WIDTH);
    localparam logic [9:0] HEIGHT_PX  = 10'(HEIGHT);
    localparam logic [9:0] BAND_M_ROW = 10'(HEIGHT / 3);
    localparam logic [9:0] BAND_B_ROW = 10'((2 * HEIGHT) / 3);

    localparam logic [2:0]  RED_MIN   = 3'd6;
    localparam logic [1:0]  BLUE_MIN  = 2'd2;
    // Exclusive upper bound for the "dark" fields (G always, R for blue pixels)
    localparam logic [2:0]  DARK_MAX  = 3'd3;
    localparam logic [14:0] MIN_COUNT = 15'd400;
    localparam logic [14:0] CNT_MAX   = 15'h7FFF;

    localparam logic [1:0] COLOR_NONE    = 2'b00;
    localparam logic [1:0] COLOR_RED     = 2'b01;
    localparam logic [1:0] COLOR_BLUE    = 2'b10;
    localparam logic [1:0] SHAPE_NONE    = 2'b00;
    localparam logic [1:0] SHAPE_TRI     = 2'b01;
    localparam logic [1:0] SHAPE_SQUARE  = 2'b10;
    localparam logic [1:0] SHAPE_DIAMOND = 2'b11;

    typedef enum logic [2:0] {
        SYNC_WAIT = 3'd0,
        ACCUM     = 3'd1,
        EVAL_A    = 3'd2,
        EVAL_B    = 3'd3,
        PUBLISH   = 3'd4
    } state_t;

    function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

    // Shape from the dominant colour's top/middle/bottom band counts, in priority order.
    function automatic logic [1:0] classify_shape(input logic [15:0] t,
                                                  input logic [15:0] m,
                                                  input logic [15:0] b);
        logic [15:0] quarter;
        logic [1:0]  s;
        quarter = {2'b00, b[15:2]};
        if (({t[14:0], 1'b0} <= b) && (t < m) && (m < b)) begin
            s = SHAPE_TRI;
        end else if ((abs_diff(t, b) <= quarter) && (abs_diff(m, b) <= quarter)) begin
            s = SHAPE_SQUARE;
        end else if ((m > t) && (m > b)) begin
            s = SHAPE_DIAMOND;
        end else begin
            s = SHAPE_NONE;
        end
        return s;
    endfunction

endpackage

// File: rtl/band_counter.sv
// Saturating 15-bit pixel counter for one colour/band pair.
module band_counter
    import treasure_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_NEG,
    input  logic        inc,
    input  logic        clr,
    output logic [14:0] count,
    output logic        sat
);

    logic [14:0] count_r;

    // Count register: clear wins over increment, value sticks at full scale.
    always_ff @(posedge CLK or negedge RESET_NEG) begin
        if (!RESET_NEG) begin
            count_r <= 15'd0;
        end else if (clr) begin
            count_r <= 15'd0;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + 15'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign sat   = (count_r == CNT_MAX);

endmodule

// File: rtl/treasure_classifier.sv
// Counts red/blue pixels per horizontal band each frame and publishes colour/shape at frame end.
// Optional macro FRAME_VOTE_EN: outputs only follow a result seen on two consecutive frames.
module treasure_classifier
    import treasure_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_NEG,
    input  logic [7:0] PIXEL_IN,
    input  logic [9:0] VGA_PIXEL_X,
    input  logic [9:0] VGA_PIXEL_Y,
    input  logic       VGA_VSYNC_NEG,
    output logic [1:0] COLOR,
    output logic [1:0] SHAPE,
    output logic       RESULT_VALID
);

    state_t      state_r, state_s;
    logic        prev_vsync_r;
    logic [9:0]  x_pipe_r [PIXEL_LATENCY];
    logic [9:0]  y_pipe_r [PIXEL_LATENCY];
    logic [9:0]  x_d_s, y_d_s;
    logic        fe_s, in_win_s, red_px_s, blue_px_s, count_en_s, clr_s;
    logic [2:0]  band_s;
    logic [5:0]  inc_s, sat_s;
    logic [14:0] cnt_s [6];
    logic [16:0] red_sum_s, blue_sum_s, dom_total_s;
    logic [16:0] red_total_r, blue_total_r;
    logic        dom_red_r;
    logic [14:0] dom_t_r, dom_m_r, dom_b_r;
    logic [1:0]  color_s, shape_s, new_color_r, new_shape_r;
    logic [1:0]  color_r, shape_r;
    logic        valid_r;

    // Delay scan coordinates to line up with the registered memory read data.
    always_ff @(posedge CLK or negedge RESET_NEG) begin
        if (!RESET_NEG) begin
            for (int i = 0; i < PIXEL_LATENCY; i++) begin
                x_pipe_r[i] <= 10'd0;
                y_pipe_r[i] <= 10'd0;
            end
        end else begin
            x_pipe_r[0] <= VGA_PIXEL_X;
            y_pipe_r[0] <= VGA_PIXEL_Y;
            for (int i = 1; i < PIXEL_LATENCY; i++) begin
                x_pipe_r[i] <= x_pipe_r[i-1];
                y_pipe_r[i] <= y_pipe_r[i-1];
            end
        end
    end

    assign x_d_s = x_pipe_r[PIXEL_LATENCY-1];
    assign y_d_s = y_pipe_r[PIXEL_LATENCY-1];

    // Vsync history for frame-end edge detection.
    always_ff @(posedge CLK or negedge RESET_NEG) begin
        if (!RESET_NEG) begin
            prev_vsync_r <= 1'b1;
        end else begin
            prev_vsync_r <= VGA_VSYNC_NEG;
        end
    end

    assign fe_s = prev_vsync_r & ~VGA_VSYNC_NEG;

    // Pixel class, band decode and per-counter increment enables.
    always_comb begin
        in_win_s  = (x_d_s < WIDTH_PX) && (y_d_s < HEIGHT_PX);
        red_px_s  = (PIXEL_IN[7:5] >= RED_MIN) && (PIXEL_IN[4:2] < DARK_MAX) &&
                    (PIXEL_IN[1:0] < BLUE_MIN);
        blue_px_s = (PIXEL_IN[1:0] >= BLUE_MIN) && (PIXEL_IN[7:5] < DARK_MAX) &&
                    (PIXEL_IN[4:2] < DARK_MAX);
        if (y_d_s < BAND_M_ROW) begin
            band_s = 3'b001;
        end else if (y_d_s < BAND_B_ROW) begin
            band_s = 3'b010;
        end else begin
            band_s = 3'b100;
        end
        count_en_s = (state_r == ACCUM) && in_win_s;
        inc_s = {{3{blue_px_s}} & band_s, {3{red_px_s}} & band_s} & {6{count_en_s}} & ~sat_s;
        clr_s = ((state_r == SYNC_WAIT) && fe_s) || (state_r == PUBLISH);
    end

    // Index 0..2: red top/mid/bottom, 3..5: blue top/mid/bottom.
    for (genvar g = 0; g < 6; g++) begin : g_cnt
        band_counter u_cnt (
            .CLK       (CLK),
            .RESET_NEG (RESET_NEG),
            .inc       (inc_s[g]),
            .clr       (clr_s),
            .count     (cnt_s[g]),
            .sat       (sat_s[g])
        );
    end

    assign red_sum_s  = {2'b00, cnt_s[0]} + {2'b00, cnt_s[1]} + {2'b00, cnt_s[2]};
    assign blue_sum_s = {2'b00, cnt_s[3]} + {2'b00, cnt_s[4]} + {2'b00, cnt_s[5]};

    // State register.
    always_ff @(posedge CLK or negedge RESET_NEG) begin
        if (!RESET_NEG) begin
            state_r <= SYNC_WAIT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state; frame ends seen during evaluation are blanking and ignored.
    always_comb begin
        state_s = state_r;
        case (state_r)
            SYNC_WAIT: begin
                if (fe_s) begin
                    state_s = ACCUM;
                end else begin
                    state_s = SYNC_WAIT;
                end
            end
            ACCUM: begin
                if (fe_s) begin
                    state_s = EVAL_A;
                end else begin
                    state_s = ACCUM;
                end
            end
            EVAL_A:  state_s = EVAL_B;
            EVAL_B:  state_s = PUBLISH;
            PUBLISH: state_s = ACCUM;
            default: state_s = SYNC_WAIT;
        endcase
    end

    // Dominant-colour snapshot in EVAL_A, classification result in EVAL_B.
    always_ff @(posedge CLK or negedge RESET_NEG) begin
        if (!RESET_NEG) begin
            red_total_r  <= 17'd0;
            blue_total_r <= 17'd0;
            dom_red_r    <= 1'b0;
            dom_t_r      <= 15'd0;
            dom_m_r      <= 15'd0;
            dom_b_r      <= 15'd0;
            new_color_r  <= COLOR_NONE;
            new_shape_r  <= SHAPE_NONE;
        end else begin
            if (state_r == EVAL_A) begin
                red_total_r  <= red_sum_s;
                blue_total_r <= blue_sum_s;
                dom_red_r    <= (red_sum_s >= blue_sum_s);
                if (red_sum_s >= blue_sum_s) begin
                    dom_t_r <= cnt_s[0];
                    dom_m_r <= cnt_s[1];
                    dom_b_r <= cnt_s[2];
                end else begin
                    dom_t_r <= cnt_s[3];
                    dom_m_r <= cnt_s[4];
                    dom_b_r <= cnt_s[5];
                end
            end
            if (state_r == EVAL_B) begin
                new_color_r <= color_s;
                new_shape_r <= shape_s;
            end
        end
    end

    // Colour and shape of the latched dominant counts.
    always_comb begin
        dom_total_s = dom_red_r ? red_total_r : blue_total_r;
        if (dom_total_s < {2'b00, MIN_COUNT}) begin
            color_s = COLOR_NONE;
            shape_s = SHAPE_NONE;
        end else begin
            color_s = dom_red_r ? COLOR_RED : COLOR_BLUE;
            shape_s = classify_shape({1'b0, dom_t_r}, {1'b0, dom_m_r}, {1'b0, dom_b_r});
        end
    end

`ifdef FRAME_VOTE_EN
    logic [3:0] cand_r;

    // Publish only when this frame repeats the previous frame's candidate.
    always_ff @(posedge CLK or negedge RESET_NEG) begin
        if (!RESET_NEG) begin
            cand_r  <= 4'd0;
            color_r <= COLOR_NONE;
            shape_r <= SHAPE_NONE;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (state_r == PUBLISH) begin
                cand_r <= {new_color_r, new_shape_r};
                if ({new_color_r, new_shape_r} == cand_r) begin
                    color_r <= new_color_r;
                    shape_r <= new_shape_r;
                    valid_r <= ({new_color_r, new_shape_r} != {color_r, shape_r});
                end
            end
        end
    end
`else
    // Every publish refreshes the outputs and strobes valid.
    always_ff @(posedge CLK or negedge RESET_NEG) begin
        if (!RESET_NEG) begin
            color_r <= COLOR_NONE;
            shape_r <= SHAPE_NONE;
            valid_r <= 1'b0;
        end else begin
            valid_r <= (state_r == PUBLISH);
            if (state_r == PUBLISH) begin
                color_r <= new_color_r;
                shape_r <= new_shape_r;
            end
        end
    end
`endif

    assign COLOR        = color_r;
    assign SHAPE        = shape_r;
    assign RESULT_VALID = valid_r;

endmodule

// File: tb/tb_treasure_classifier.sv
// Directed scoreboard bench for treasure_classifier: synthetic frames, per-publish checks.
// With FRAME_VOTE_EN defined it runs the two-frame vote sequence instead of the main one.
module tb_treasure_classifier;

    logic       CLK           = 1'b0;
    logic       RESET_NEG     = 1'b1;
    logic [7:0] PIXEL_IN      = 8'h00;
    logic [9:0] VGA_PIXEL_X   = 10'd0;
    logic [9:0] VGA_PIXEL_Y   = 10'd300;
    logic       VGA_VSYNC_NEG = 1'b1;
    logic [1:0] COLOR;
    logic [1:0] SHAPE;
    logic       RESULT_VALID;

    typedef struct {
        logic [1:0] color;
        logic [1:0] shape;
        int         fe_cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         tests   = 0;
    int         fails   = 0;
    int         cyc     = 0;
    logic [7:0] pend_pix = 8'h00;
    logic [1:0] hold_c  = 2'b00;
    logic [1:0] hold_s  = 2'b00;

    treasure_classifier dut (
        .CLK           (CLK),
        .RESET_NEG     (RESET_NEG),
        .PIXEL_IN      (PIXEL_IN),
        .VGA_PIXEL_X   (VGA_PIXEL_X),
        .VGA_PIXEL_Y   (VGA_PIXEL_Y),
        .VGA_VSYNC_NEG (VGA_VSYNC_NEG),
        .COLOR         (COLOR),
        .SHAPE         (SHAPE),
        .RESULT_VALID  (RESULT_VALID)
    );

    always #20 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One pixel clock: memory returns the previous position's pixel, as the M9K would.
    task automatic step(input logic [9:0] x, input logic [9:0] y, input logic [7:0] pix,
                        input logic vs);
        exp_t e;
        PIXEL_IN      = pend_pix;
        VGA_PIXEL_X   = x;
        VGA_PIXEL_Y   = y;
        VGA_VSYNC_NEG = vs;
        pend_pix      = pix;
        @(posedge CLK);
        #1;
        cyc++;
        if (RESULT_VALID === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 32'(RESULT_VALID), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("color", 32'(COLOR), 32'(e.color));
                chk("shape", 32'(SHAPE), 32'(e.shape));
                chk("valid_latency", cyc, e.fe_cyc + 4);
                hold_c = e.color;
                hold_s = e.shape;
            end
        end
    endtask

    task automatic emit_rows(input int row0, input int n, input logic [7:0] pix);
        for (int i = 0; i < n; i++) begin
            step(10'(i % 176), 10'(row0 + i / 176), pix, 1'b1);
        end
    endtask

    task automatic emit_oow(input int n, input logic [7:0] pix);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) begin
                step(10'(176 + (i / 2) % 24), 10'((i / 2) % 144), pix, 1'b1);
            end else begin
                step(10'((i / 2) % 176), 10'(144 + (i / 2) % 16), pix, 1'b1);
            end
        end
    endtask

    // Vsync falls at cycle N; with inject, red in-window pixels land in EVAL_A..PUBLISH.
    task automatic frame_end(input bit push, input logic [1:0] c, input logic [1:0] s,
                             input bit glitch, input bit inject);
        exp_t e;
        logic [7:0] p;
        logic [9:0] yy;
        p  = inject ? 8'hE0 : 8'h00;
        yy = inject ? 10'd0 : 10'd300;
        step(10'd0, 10'd300, 8'h00, 1'b1);
        if (push) begin
            e.color  = c;
            e.shape  = s;
            e.fe_cyc = cyc;
            sb_q.push_back(e);
        end
        step(10'd0, yy, p, 1'b0);
        step(10'd1, yy, p, 1'b0);
        step(10'd2, yy, p, glitch ? 1'b1 : 1'b0);
        for (int i = 0; i < 6; i++) step(10'd0, 10'd300, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) step(10'd0, 10'd300, 8'h00, 1'b1);
        chk("hold_color", 32'(COLOR), 32'(hold_c));
        chk("hold_shape", 32'(SHAPE), 32'(hold_s));
    endtask

    initial begin
        #5 RESET_NEG = 1'b0;
        #5;
        chk("rst_color", 32'(COLOR), 32'd0);
        chk("rst_shape", 32'(SHAPE), 32'd0);
        chk("rst_valid", 32'(RESULT_VALID), 32'd0);
        step(10'd0, 10'd300, 8'h00, 1'b1);
        step(10'd0, 10'd300, 8'h00, 1'b1);
        RESET_NEG = 1'b1;

        // Partial frame after reset is discarded
        emit_rows(0, 500, 8'hE0);
        frame_end(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

`ifdef FRAME_VOTE_EN
        emit_rows(0, 1000, 8'hE0);
        emit_rows(48, 1000, 8'hE0);
        emit_rows(96, 1000, 8'hE0);
        frame_end(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            emit_rows(0, 100, 8'h03);
            emit_rows(48, 300, 8'h03);
            emit_rows(96, 600, 8'h03);
            frame_end(k == 1, 2'b10, 2'b01, 1'b0, 1'b1);
        end
`else
        // Full red frame: equal bands, square
        emit_rows(0, 8448, 8'hE0);
        emit_rows(48, 8448, 8'hE0);
        emit_rows(96, 8448, 8'hE0);
        frame_end(1'b1, 2'b01, 2'b10, 1'b0, 1'b1);

        // Blue triangle, with a vsync glitch during evaluation
        emit_rows(0, 1000, 8'h03);
        emit_rows(48, 3000, 8'h03);
        emit_rows(96, 6000, 8'h03);
        frame_end(1'b1, 2'b10, 2'b01, 1'b1, 1'b1);

        // Band-edge rows 47/48/96 and column 175: red triangle
        emit_rows(47, 176, 8'hE0);
        emit_rows(48, 200, 8'hE0);
        emit_rows(96, 400, 8'hE0);
        frame_end(1'b1, 2'b01, 2'b01, 1'b0, 1'b1);

        // Nothing qualifies as red or blue
        emit_rows(96, 500, 8'h1C);
        emit_rows(96, 500, 8'hA0);
        emit_rows(96, 500, 8'hEC);
        emit_rows(96, 500, 8'hE2);
        emit_rows(96, 500, 8'h0F);
        emit_rows(96, 500, 8'h63);
        frame_end(1'b1, 2'b00, 2'b00, 1'b0, 1'b1);

        // 300 red in window, 400 red outside
        emit_rows(0, 300, 8'hE0);
        emit_oow(400, 8'hE0);
        frame_end(1'b1, 2'b00, 2'b00, 1'b0, 1'b1);

        // Detection threshold: 399 misses, 400 hits
        emit_rows(96, 399, 8'hE0);
        frame_end(1'b1, 2'b00, 2'b00, 1'b0, 1'b1);
        emit_rows(96, 400, 8'hE0);
        frame_end(1'b1, 2'b01, 2'b00, 1'b0, 1'b1);

        // Red diamond
        emit_rows(0, 500, 8'hE0);
        emit_rows(48, 4000, 8'hE0);
        emit_rows(96, 500, 8'hE0);
        frame_end(1'b1, 2'b01, 2'b11, 1'b0, 1'b1);

        // Red/blue tie goes to red
        emit_rows(48, 3000, 8'hE0);
        emit_rows(0, 1000, 8'h03);
        emit_rows(48, 1000, 8'h03);
        emit_rows(96, 1000, 8'h03);
        frame_end(1'b1, 2'b01, 2'b11, 1'b0, 1'b1);

        // Reset in the middle of accumulation
        emit_rows(48, 2000, 8'hE0);
        RESET_NEG = 1'b0;
        #1;
        chk("midrst_color", 32'(COLOR), 32'd0);
        chk("midrst_shape", 32'(SHAPE), 32'd0);
        chk("midrst_valid", 32'(RESULT_VALID), 32'd0);
        hold_c = 2'b00;
        hold_s = 2'b00;
        step(10'd0, 10'd300, 8'h00, 1'b1);
        step(10'd0, 10'd300, 8'h00, 1'b1);
        RESET_NEG = 1'b1;
        emit_rows(48, 300, 8'hE0);
        frame_end(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
        emit_rows(0, 100, 8'h03);
        emit_rows(48, 300, 8'h03);
        emit_rows(96, 600, 8'h03);
        frame_end(1'b1, 2'b10, 2'b01, 1'b0, 1'b1);
`endif

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
